load_unit: RTL and testbench

- Sits between the processor core's execute stage and the word-organised memory block.
- Accepts one load request at a time and issues a single-cycle read strobe with a word-aligned address.
- Waits a fixed memory latency, then extracts the byte, halfword or word from the returned data, sign- or zero-extending it.
- Returns the result and its destination register through a valid/ready handshake. Misaligned or illegal loads are flagged and never touch memory.

---
 rtl/load_unit.sv | 152 +++++++++++++++
 tb/tb_load_unit.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_unit.sv
// rtl/load_unit.sv - RV32I load unit between execute stage and word memory
//
// Accepts one load at a time, strobes a word-aligned read, waits MEM_LATENCY
// edges, then extracts and sign/zero-extends the byte, halfword or word.
// Misaligned loads and illegal funct3 codes are answered with rsp_error=1
// and never reach memory.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   req_valid/req_ready         request handshake (ready only when idle)
//   req_addr/req_funct3/req_rd  byte address, RV32I load funct3, dest register
//   mem_addr/mem_rstrb          word-aligned read address, one-cycle strobe
//   mem_rdata                   read data, sampled MEM_LATENCY edges after strobe
//   rsp_valid/rsp_ready         response handshake
//   rsp_data/rsp_rd/rsp_error   extended result, dest register, error flag
module load_unit #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [4:0]  req_rd,
  output logic [31:0] mem_addr,
  output logic        mem_rstrb,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic        rsp_error
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;
  logic [1:0]  r_cnt;
  logic [31:0] r_mem_addr;
  logic        r_mem_rstrb;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_data;
  logic [4:0]  r_rsp_rd;
  logic        r_rsp_error;

  logic        w_req_err;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  assign req_ready = (r_state == S_IDLE);
  assign mem_addr  = r_mem_addr;
  assign mem_rstrb = r_mem_rstrb;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_rd    = r_rsp_rd;
  assign rsp_error = r_rsp_error;

  // Illegal funct3 or an address not aligned to the access size.
  always_comb begin
    w_req_err = 1'b0;
    case (req_funct3)
      3'd0, 3'd4: w_req_err = 1'b0;
      3'd1, 3'd5: w_req_err = req_addr[0];
      3'd2:       w_req_err = |req_addr[1:0];
      default:    w_req_err = 1'b1;
    endcase
  end

  // Lane selection uses the byte offset captured at accept time.
  always_comb begin
    w_byte = mem_rdata[{r_lane, 3'b000} +: 8];
    w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_funct3)
      3'd0:    w_ext = {{24{w_byte[7]}}, w_byte};
      3'd4:    w_ext = {24'd0, w_byte};
      3'd1:    w_ext = {{16{w_half[15]}}, w_half};
      3'd5:    w_ext = {16'd0, w_half};
      default: w_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_state_nxt = w_req_err ? S_RESP : S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (r_cnt == 2'd0) w_state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_funct3    <= 3'd0;
      r_lane      <= 2'd0;
      r_cnt       <= 2'd0;
      r_mem_addr  <= 32'd0;
      r_mem_rstrb <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 32'd0;
      r_rsp_rd    <= 5'd0;
      r_rsp_error <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_funct3    <= req_funct3;
            r_lane      <= req_addr[1:0];
            r_rsp_rd    <= req_rd;
            r_rsp_error <= w_req_err;
            if (w_req_err) begin
              // Error loads skip memory; mem_addr keeps the last good address.
              r_rsp_data  <= 32'd0;
              r_rsp_valid <= 1'b1;
            end else begin
              r_mem_addr  <= {req_addr[31:2], 2'b00};
              r_mem_rstrb <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          r_mem_rstrb <= 1'b0;
          r_cnt       <= 2'(MEM_LATENCY - 1);
        end
        S_WAIT: begin
          if (r_cnt == 2'd0) begin
            r_rsp_data  <= w_ext;
            r_rsp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// tb/tb_load_unit.sv - scoreboard testbench for load_unit
module tb_load_unit;

  localparam int LAT  = 1;
  localparam int LAT3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A (MEM_LATENCY=1)
  logic        resetn, req_valid, req_ready, mem_rstrb, rsp_valid, rsp_ready, rsp_error;
  logic [31:0] req_addr, mem_addr, mem_rdata, rsp_data;
  logic [2:0]  req_funct3;
  logic [4:0]  req_rd, rsp_rd;

  // DUT B (MEM_LATENCY=3)
  logic        resetn_b, req_valid_b, req_ready_b, mem_rstrb_b, rsp_valid_b, rsp_ready_b, rsp_error_b;
  logic [31:0] req_addr_b, mem_addr_b, mem_rdata_b, rsp_data_b;
  logic [2:0]  req_funct3_b;
  logic [4:0]  req_rd_b, rsp_rd_b;

  load_unit #(.MEM_LATENCY(LAT)) u_dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_rd(req_rd),
    .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_rd(rsp_rd), .rsp_error(rsp_error)
  );

  load_unit #(.MEM_LATENCY(LAT3)) u_dut_b (
    .clk(clk), .resetn(resetn_b), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_addr(req_addr_b), .req_funct3(req_funct3_b), .req_rd(req_rd_b),
    .mem_addr(mem_addr_b), .mem_rstrb(mem_rstrb_b), .mem_rdata(mem_rdata_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_data(rsp_data_b),
    .rsp_rd(rsp_rd_b), .rsp_error(rsp_error_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Word memory shared by both memory models, indexed by address bits [9:2].
  logic [31:0] mem [256];

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  bit          busy = 1'b0;
  bit          prev_valid = 1'b0;
  int          cyc = 0;
  exp_t        mon_e;

  // Reference: RV32I load semantics with plain arithmetic.
  function automatic exp_t model(input logic [31:0] a, input logic [2:0] f,
                                 input logic [4:0] rd, input int acc);
    exp_t        e;
    logic [31:0] w;
    int unsigned b, h;
    w = mem[(a / 4) % 256];
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    e.rd   = rd;
    e.acc  = acc;
    e.data = 32'd0;
    e.err  = (f == 3'd3 || f > 3'd5) || ((f == 3'd1 || f == 3'd5) && (a % 2 != 0)) ||
             (f == 3'd2 && (a % 4 != 0));
    if (!e.err) begin
      case (f)
        3'd0:    e.data = (b >= 128)   ? b - 256   : b;
        3'd1:    e.data = (h >= 32768) ? h - 65536 : h;
        3'd4:    e.data = b;
        3'd5:    e.data = h;
        default: e.data = w;
      endcase
    end
    return e;
  endfunction

  // Memory model A: data valid LAT edges after the strobed cycle, garbage otherwise.
  bit          pend_a = 1'b0;
  int          pend_cnt_a = 0;
  logic [31:0] pend_addr_a = 32'd0;
  always @(posedge clk) begin
    if (mem_rstrb) begin
      pend_addr_a = mem_addr;
      pend_a      = 1'b1;
      pend_cnt_a  = LAT - 1;
    end else if (pend_a) begin
      pend_cnt_a--;
    end
    if (pend_a && pend_cnt_a == 0) begin
      mem_rdata <= mem[pend_addr_a[9:2]];
      pend_a = 1'b0;
    end else begin
      mem_rdata <= $urandom;
    end
  end

  bit          pend_b = 1'b0;
  int          pend_cnt_b = 0;
  logic [31:0] pend_addr_b = 32'd0;
  always @(posedge clk) begin
    if (mem_rstrb_b) begin
      pend_addr_b = mem_addr_b;
      pend_b      = 1'b1;
      pend_cnt_b  = LAT3 - 1;
    end else if (pend_b) begin
      pend_cnt_b--;
    end
    if (pend_b && pend_cnt_b == 0) begin
      mem_rdata_b <= mem[pend_addr_b[9:2]];
      pend_b = 1'b0;
    end else begin
      mem_rdata_b <= $urandom;
    end
  end

  // Handshake observer: push expectations at accept, retire at response handshake.
  always @(posedge clk) begin
    cyc++;
    if (resetn) begin
      if (req_valid && req_ready) begin
        check("accept_while_busy", busy, 1'b0);
        mon_e = model(req_addr, req_funct3, req_rd, cyc);
        exp_q.push_back(mon_e);
        if (!mon_e.err) addr_q.push_back({req_addr[31:2], 2'b00});
        busy = 1'b1;
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        busy = 1'b0;
      end
    end
  end

  // Output checker, sampled mid-cycle.
  always @(negedge clk) begin
    if (!resetn) begin
      prev_valid = 1'b0;
    end else begin
      check("req_ready", req_ready, !busy);
      if (mem_rstrb) begin
        if (addr_q.size() == 0) fail_now("unexpected_mem_rstrb");
        else check("mem_addr", mem_addr, addr_q.pop_front());
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          fail_now("stale_response");
        end else begin
          check("rsp_data", rsp_data, exp_q[0].data);
          check("rsp_rd", rsp_rd, exp_q[0].rd);
          check("rsp_error", rsp_error, exp_q[0].err);
          // An error response is raised by the accepting edge itself.
          if (!prev_valid)
            check("latency", cyc - exp_q[0].acc, exp_q[0].err ? 0 : LAT + 1);
        end
      end
      prev_valid = rsp_valid;
    end
  end

  bit rdy_rand = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) rsp_ready = ($urandom % 3) != 0;
    end
  end

  task automatic do_load(input logic [31:0] a, input logic [2:0] f, input logic [4:0] rd);
    int n = 0;
    req_valid  = 1'b1;
    req_addr   = a;
    req_funct3 = f;
    req_rd     = rd;
    while (!req_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) fail_now("req_ready_timeout");
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_addr   = $urandom;
    req_funct3 = 3'($urandom);
    req_rd     = 5'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) fail_now("idle_timeout");
  endtask

  task automatic abort_load();
    exp_q.delete();
    addr_q.delete();
    busy = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  logic [31:0] d_addr [10] = '{32'd400, 32'd415, 32'd415, 32'd401, 32'd414,
                               32'd414, 32'd400, 32'd401, 32'd413, 32'd400};
  logic [2:0]  d_f3   [10] = '{3'd2, 3'd0, 3'd4, 3'd0, 3'd1, 3'd5, 3'd1, 3'd2, 3'd1, 3'd3};

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int strobes;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[100] = 32'h04030201;
    mem[103] = 32'hFF0F0E0D;

    resetn = 1'b0; req_valid = 1'b0; req_addr = '0; req_funct3 = '0; req_rd = '0;
    rsp_ready = 1'b1;
    resetn_b = 1'b0; req_valid_b = 1'b0; req_addr_b = '0; req_funct3_b = '0; req_rd_b = '0;
    rsp_ready_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_mem_rstrb", mem_rstrb, 1'b0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_rd", rsp_rd, 5'd0);
    check("rst_rsp_error", rsp_error, 1'b0);
    resetn = 1'b1;
    resetn_b = 1'b1;

    for (int i = 0; i < 10; i++) do_load(d_addr[i], d_f3[i], 5'(10 + i));
    wait_idle();

    // Back-pressure with a second request waiting.
    rsp_ready = 1'b0;
    do_load(32'd412, 3'd2, 5'd7);
    fork
      do_load(32'd400, 3'd2, 5'd8);
      begin
        n = 0;
        while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) fail_now("bp_rsp_timeout");
        repeat (5) begin
          @(posedge clk);
          #1;
          check("bp_hold_valid", rsp_valid, 1'b1);
          check("bp_hold_data", rsp_data, 32'hFF0F0E0D);
          check("bp_req_ready", req_ready, 1'b0);
        end
        rsp_ready = 1'b1;
      end
    join
    wait_idle();

    // Reset during ISSUE: strobe drops at once.
    do_load(32'd400, 3'd2, 5'd3);
    resetn = 1'b0;
    #1;
    check("rst_issue_rstrb", mem_rstrb, 1'b0);
    check("rst_issue_valid", rsp_valid, 1'b0);
    abort_load();

    // Reset during WAIT.
    do_load(32'd400, 3'd2, 5'd4);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check("rst_wait_rstrb", mem_rstrb, 1'b0);
    check("rst_wait_valid", rsp_valid, 1'b0);
    check("rst_wait_ready", req_ready, 1'b1);
    abort_load();
    repeat (8) @(posedge clk);
    #1;
    check("post_rst_ready", req_ready, 1'b1);

    // Randomized traffic with random back-pressure.
    rdy_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      do_load($urandom, 3'($urandom_range(0, 7)), 5'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rdy_rand = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();
    check("scoreboard_empty", exp_q.size(), 0);

    // MEM_LATENCY=3 instance: LW 400.
    req_valid_b = 1'b1; req_addr_b = 32'd400; req_funct3_b = 3'd2; req_rd_b = 5'd10;
    check("b_req_ready", req_ready_b, 1'b1);
    @(posedge clk);
    #1;
    req_valid_b = 1'b0;
    n = 0;
    strobes = 0;
    while (!rsp_valid_b && n < 20) begin
      if (mem_rstrb_b) begin
        strobes++;
        check("b_mem_addr", mem_addr_b, 32'd400);
      end
      @(posedge clk);
      #1;
      n++;
    end
    check("b_latency", n, LAT3 + 1);
    check("b_strobes", strobes, 1);
    check("b_rsp_data", rsp_data_b, 32'h04030201);
    check("b_rsp_rd", rsp_rd_b, 5'd10);
    check("b_rsp_error", rsp_error_b, 1'b0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
